// File: rtl/id_stage_hz.sv
// RV32 instruction-decode stage with branch/jump resolution in ID, a valid/ready
// ID/EX register and a hazard unit (load-use, branch-operand stalls, wrong-path squash).
module id_stage_hz #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CTRL_W = 9
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_valid,
    input  logic [XLEN-1:0]   if_pc,
    input  logic [XLEN-1:0]   if_pc4,
    input  logic [31:0]       if_instr,
    output logic              id_ready,
    output logic [REG_AW-1:0] rs1_addr,
    output logic [REG_AW-1:0] rs2_addr,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc4,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              illegal
);

    typedef enum logic [2:0] {
        OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_BAD
    } op_e;

    op_e               op;
    logic [2:0]        funct3;
    logic [31:0]       imm32;
    logic [XLEN-1:0]   imm;
    logic [8:0]        ctrl9;
    logic              use_rs1, use_rs2, br_like, taken, legal;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   pc_target, jalr_target;
    logic              ex_hit, mem_hit, stall, ex_upd, accept;

    logic              ex_valid_q, ex_valid_d;
    logic [XLEN-1:0]   ex_pc4_q, ex_pc4_d, ex_rs1_data_q, ex_rs1_data_d;
    logic [XLEN-1:0]   ex_rs2_data_q, ex_rs2_data_d, ex_imm_q, ex_imm_d;
    logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d, ex_rd_q, ex_rd_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic              illegal_q, illegal_d;
    logic              kill_next_q, kill_next_d;
    logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
    logic              mem_load_q, mem_load_d;

    // Decode: opcode class, immediate, control word, register fields
    always_comb begin
        funct3 = if_instr[14:12];
        case (if_instr[6:0])
            7'b0110011: op = OP_R;
            7'b0010011: op = OP_I;
            7'b0000011: op = OP_LOAD;
            7'b0100011: op = OP_STORE;
            7'b1100011: op = OP_BRANCH;
            7'b1101111: op = OP_JAL;
            7'b1100111: op = OP_JALR;
            default:    op = OP_BAD;
        endcase

        case (op)
            OP_STORE:  imm32 = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            OP_BRANCH: imm32 = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                                if_instr[30:25], if_instr[11:8], 1'b0};
            OP_JAL:    imm32 = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                                if_instr[20], if_instr[30:21], 1'b0};
            OP_I, OP_LOAD, OP_JALR: imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
            default:   imm32 = '0;
        endcase
        imm = XLEN'($signed(imm32));

        case (op)
            OP_R: begin
                case (funct3)
                    3'b000:  ctrl9 = if_instr[30] ? 9'h042 : 9'h040;
                    3'b001:  ctrl9 = 9'h048;
                    3'b010:  ctrl9 = 9'h04A;
                    3'b110:  ctrl9 = 9'h046;
                    3'b111:  ctrl9 = 9'h044;
                    default: ctrl9 = 9'h040;
                endcase
            end
            OP_I:            ctrl9 = 9'h041;
            OP_LOAD:         ctrl9 = 9'h0E1;
            OP_STORE:        ctrl9 = 9'h011;
            OP_JAL, OP_JALR: ctrl9 = 9'h140;
            default:         ctrl9 = 9'h000;
        endcase

        use_rs1  = op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
        use_rs2  = op inside {OP_R, OP_STORE, OP_BRANCH};
        br_like  = (op == OP_BRANCH) || (op == OP_JALR);
        legal    = (op != OP_BAD);
        rs1_addr = use_rs1 ? REG_AW'(if_instr[19:15]) : '0;
        rs2_addr = use_rs2 ? REG_AW'(if_instr[24:20]) : '0;
        rd       = ctrl9[6] ? REG_AW'(if_instr[11:7]) : '0;
    end

    // Branch resolution and targets
    always_comb begin
        case (funct3)
            3'b000:  taken = (rs1_data == rs2_data);
            3'b001:  taken = (rs1_data != rs2_data);
            3'b100:  taken = ($signed(rs1_data) <  $signed(rs2_data));
            3'b101:  taken = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110:  taken = (rs1_data <  rs2_data);
            3'b111:  taken = (rs1_data >= rs2_data);
            default: taken = 1'b0;
        endcase
        pc_target   = if_pc + imm;
        jalr_target = (rs1_data + imm) & ~{{(XLEN-1){1'b0}}, 1'b1};
    end

    // Hazard unit: unused sources read as x0, so the nonzero-rd test excludes them
    always_comb begin
        ex_hit  = ex_valid_q && (ex_rd_q != '0) &&
                  ((ex_rd_q == rs1_addr) || (ex_rd_q == rs2_addr));
        mem_hit = mem_load_q && (mem_rd_q != '0) &&
                  ((mem_rd_q == rs1_addr) || (mem_rd_q == rs2_addr));
        stall   = if_valid && !kill_next_q &&
                  ((ex_hit && ex_ctrl_q[5]) ||
                   (br_like && ex_hit && ex_ctrl_q[6]) ||
                   (br_like && mem_hit));
        ex_upd  = ex_ready || !ex_valid_q;
        id_ready = !stall && ex_upd;
        accept  = if_valid && id_ready && !kill_next_q;
        redirect_valid = accept && ((op == OP_JAL) || (op == OP_JALR) ||
                                    ((op == OP_BRANCH) && taken));
        redirect_pc = (op == OP_JALR) ? jalr_target : pc_target;
    end

    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_pc4_d      = ex_pc4_q;
        ex_rs1_data_d = ex_rs1_data_q;
        ex_rs2_data_d = ex_rs2_data_q;
        ex_imm_d      = ex_imm_q;
        ex_rs1_d      = ex_rs1_q;
        ex_rs2_d      = ex_rs2_q;
        ex_rd_d       = ex_rd_q;
        ex_ctrl_d     = ex_ctrl_q;
        kill_next_d   = kill_next_q;
        mem_rd_d      = mem_rd_q;
        mem_load_d    = mem_load_q;
        illegal_d     = accept && !legal;

        if (ex_upd) begin
            ex_valid_d = accept && legal;
            if (accept && legal) begin
                ex_pc4_d      = if_pc4;
                ex_rs1_data_d = rs1_data;
                ex_rs2_data_d = rs2_data;
                ex_imm_d      = imm;
                ex_rs1_d      = rs1_addr;
                ex_rs2_d      = rs2_addr;
                ex_rd_d       = rd;
                ex_ctrl_d     = CTRL_W'(ctrl9);
            end
        end

        // Only the one wrong-path instruction following a redirect is squashed
        if (redirect_valid)
            kill_next_d = 1'b1;
        else if (if_valid && id_ready && kill_next_q)
            kill_next_d = 1'b0;

        if (ex_valid_q && ex_ready) begin
            mem_rd_d   = ex_rd_q;
            mem_load_d = ex_ctrl_q[5];
        end else if (ex_ready) begin
            mem_rd_d   = '0;
            mem_load_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid_q    <= 1'b0;
            ex_pc4_q      <= '0;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
            ex_imm_q      <= '0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_rd_q       <= '0;
            ex_ctrl_q     <= '0;
            illegal_q     <= 1'b0;
            kill_next_q   <= 1'b0;
            mem_rd_q      <= '0;
            mem_load_q    <= 1'b0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_pc4_q      <= ex_pc4_d;
            ex_rs1_data_q <= ex_rs1_data_d;
            ex_rs2_data_q <= ex_rs2_data_d;
            ex_imm_q      <= ex_imm_d;
            ex_rs1_q      <= ex_rs1_d;
            ex_rs2_q      <= ex_rs2_d;
            ex_rd_q       <= ex_rd_d;
            ex_ctrl_q     <= ex_ctrl_d;
            illegal_q     <= illegal_d;
            kill_next_q   <= kill_next_d;
            mem_rd_q      <= mem_rd_d;
            mem_load_q    <= mem_load_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_pc4      = ex_pc4_q;
    assign ex_rs1_data = ex_rs1_data_q;
    assign ex_rs2_data = ex_rs2_data_q;
    assign ex_imm      = ex_imm_q;
    assign ex_rs1      = ex_rs1_q;
    assign ex_rs2      = ex_rs2_q;
    assign ex_rd       = ex_rd_q;
    assign ex_ctrl     = ex_ctrl_q;
    assign illegal     = illegal_q;

endmodule
